// File: rtl/enigma_rotor_ctrl.sv
// Rotor-position controller ahead of the Enigma encoding pipeline.
// Steps rotors per key (with double step) and emits per-stage delayed copies.
module enigma_rotor_ctrl #(
  parameter int LETTERS  = 26,
  parameter int R1_INIT  = 1,
  parameter int R2_INIT  = 1,
  parameter int R3_INIT  = 1,
  parameter int R1_NOTCH = 22,
  parameter int R2_NOTCH = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rotors_rst_i,
  input  logic            ld_i,
  input  logic [6:0]      ld_r1_i,
  input  logic [6:0]      ld_r2_i,
  input  logic [6:0]      ld_r3_i,
  input  logic [6:0]      in_symb_i,
  input  logic            en_val_i,
  output logic [6:0]      in_symb_o,
  output logic            en_val_o,
  output logic [6:0]      r1_o,
  output logic [6:0]      r2_o,
  output logic [6:0]      r3_o,
  output logic [5:1][6:0] r1_d_o,
  output logic [4:1][6:0] r2_d_o,
  output logic [3:1][6:0] r3_d_o
);

  localparam logic [6:0] LTR = 7'(LETTERS);
  localparam logic [6:0] I1  = 7'(R1_INIT);
  localparam logic [6:0] I2  = 7'(R2_INIT);
  localparam logic [6:0] I3  = 7'(R3_INIT);
  localparam logic [6:0] N1  = 7'(R1_NOTCH);
  localparam logic [6:0] N2  = 7'(R2_NOTCH);

  logic [6:0] p1, p2, p3;
  logic [6:0] b1, b2, b3;
  logic [6:0] n1, n2, n3;
  logic       ld_ok;

  function automatic logic [6:0] inc(input logic [6:0] x);
    if (x == LTR) return 7'd1;
    return x + 7'd1;
  endfunction

  function automatic logic in_rng(input logic [6:0] x);
    return (x != 7'd0) && (x <= LTR);
  endfunction

  // A load with any out-of-range position is dropped as a whole
  assign ld_ok = ld_i
               && in_rng(ld_r1_i)
               && in_rng(ld_r2_i)
               && in_rng(ld_r3_i);

  always_comb begin
    b1 = p1;
    b2 = p2;
    b3 = p3;
    if (rotors_rst_i) begin
      b1 = I1;
      b2 = I2;
      b3 = I3;
    end else if (ld_ok) begin
      b1 = ld_r1_i;
      b2 = ld_r2_i;
      b3 = ld_r3_i;
    end
  end

  always_comb begin
    n1 = b1;
    n2 = b2;
    n3 = b3;
    if (en_val_i) begin
      n1 = inc(b1);
      if (b2 == N2) begin
        n2 = inc(b2);
        n3 = inc(b3);
      end else if (b1 == N1) begin
        n2 = inc(b2);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p1        <= I1;
      p2        <= I2;
      p3        <= I3;
      in_symb_o <= 7'd0;
      en_val_o  <= 1'b0;
      r1_d_o    <= {5{I1}};
      r2_d_o    <= {4{I2}};
      r3_d_o    <= {3{I3}};
    end else begin
      p1        <= n1;
      p2        <= n2;
      p3        <= n3;
      in_symb_o <= in_symb_i;
      en_val_o  <= en_val_i;
      r1_d_o    <= {r1_d_o[4:1], p1};
      r2_d_o    <= {r2_d_o[3:1], p2};
      r3_d_o    <= {r3_d_o[2:1], p3};
    end
  end

  assign r1_o = p1;
  assign r2_o = p2;
  assign r3_o = p3;

endmodule

// File: tb/tb_enigma_rotor_ctrl.sv
// Bench for enigma_rotor_ctrl: vector table, scoreboard and delay-line model.
// A second instance with both notches at 26 covers the full wrap case.
module tb_enigma_rotor_ctrl;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            rotors_rst_i = 1'b0;
  logic            ld_i = 1'b0;
  logic [6:0]      ld_r1_i = '0;
  logic [6:0]      ld_r2_i = '0;
  logic [6:0]      ld_r3_i = '0;
  logic [6:0]      in_symb_i = '0;
  logic            en_val_i = 1'b0;

  logic [6:0]      in_symb_o, b_in_symb_o;
  logic            en_val_o, b_en_val_o;
  logic [6:0]      r1_o, r2_o, r3_o;
  logic [6:0]      b_r1_o, b_r2_o, b_r3_o;
  logic [5:1][6:0] r1_d_o, b_r1_d_o;
  logic [4:1][6:0] r2_d_o, b_r2_d_o;
  logic [3:1][6:0] r3_d_o, b_r3_d_o;

  enigma_rotor_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rotors_rst_i(rotors_rst_i), .ld_i(ld_i),
    .ld_r1_i(ld_r1_i), .ld_r2_i(ld_r2_i), .ld_r3_i(ld_r3_i),
    .in_symb_i(in_symb_i), .en_val_i(en_val_i),
    .in_symb_o(in_symb_o), .en_val_o(en_val_o),
    .r1_o(r1_o), .r2_o(r2_o), .r3_o(r3_o),
    .r1_d_o(r1_d_o), .r2_d_o(r2_d_o), .r3_d_o(r3_d_o)
  );

  enigma_rotor_ctrl #(.R1_NOTCH(26), .R2_NOTCH(26)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .rotors_rst_i(rotors_rst_i), .ld_i(ld_i),
    .ld_r1_i(ld_r1_i), .ld_r2_i(ld_r2_i), .ld_r3_i(ld_r3_i),
    .in_symb_i(in_symb_i), .en_val_i(en_val_i),
    .in_symb_o(b_in_symb_o), .en_val_o(b_en_val_o),
    .r1_o(b_r1_o), .r2_o(b_r2_o), .r3_o(b_r3_o),
    .r1_d_o(b_r1_d_o), .r2_d_o(b_r2_d_o), .r3_d_o(b_r3_d_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rr;
    logic       ld;
    logic [6:0] l3, l2, l1;
    logic       en;
    logic [6:0] sym;
    logic [6:0] e3, e2, e1;
  } vec_t;

  typedef struct packed {
    logic [6:0] s, p3, p2, p1;
  } sb_t;

  vec_t tbl[15];
  sb_t  sbq[$];
  int   h1[$], h2[$], h3[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m1, m2, m3;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rr, input logic ld,
    input int l3, input int l2, input int l1,
    input logic en, input int sym,
    input int e3, input int e2, input int e1);
    vec_t v;
    v.rr = rr; v.ld = ld;
    v.l3 = 7'(l3); v.l2 = 7'(l2); v.l1 = 7'(l1);
    v.en = en; v.sym = 7'(sym);
    v.e3 = 7'(e3); v.e2 = 7'(e2); v.e1 = 7'(e1);
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, " r1_o"}, r1_o, 1);
    chk({tag, " r2_o"}, r2_o, 1);
    chk({tag, " r3_o"}, r3_o, 1);
    chk({tag, " en_val_o"}, en_val_o, 0);
    chk({tag, " in_symb_o"}, in_symb_o, 0);
    for (int k = 1; k <= 5; k++) chk($sformatf("%s r1_d[%0d]", tag, k), r1_d_o[k], 1);
    for (int k = 1; k <= 4; k++) chk($sformatf("%s r2_d[%0d]", tag, k), r2_d_o[k], 1);
    for (int k = 1; k <= 3; k++) chk($sformatf("%s r3_d[%0d]", tag, k), r3_d_o[k], 1);
  endtask

  // Drive one cycle, push the expectation, then check after the edge
  task automatic drive(input string tag, input vec_t v);
    sb_t e;
    rotors_rst_i = v.rr;
    ld_i = v.ld;
    ld_r3_i = v.l3; ld_r2_i = v.l2; ld_r1_i = v.l1;
    en_val_i = v.en;
    in_symb_i = v.sym;
    if (v.en) begin
      e.s = v.sym; e.p3 = v.e3; e.p2 = v.e2; e.p1 = v.e1;
      sbq.push_back(e);
    end
    @(posedge clk_i);
    #1;
    chk({tag, " en_val_o"}, en_val_o, v.en);
    chk({tag, " r1_o"}, r1_o, v.e1);
    chk({tag, " r2_o"}, r2_o, v.e2);
    chk({tag, " r3_o"}, r3_o, v.e3);
    if (en_val_o) begin
      if (sbq.size() == 0) begin
        chk({tag, " sb_underflow"}, 1, 0);
      end else begin
        e = sbq.pop_front();
        chk({tag, " sb in_symb_o"}, in_symb_o, e.s);
        chk({tag, " sb r1"}, r1_o, e.p1);
        chk({tag, " sb r2"}, r2_o, e.p2);
        chk({tag, " sb r3"}, r3_o, e.p3);
      end
    end
  endtask

  function automatic int inc(input int x);
    return (x == 26) ? 1 : x + 1;
  endfunction

  task automatic mdl(input vec_t v);
    int c1, c2, c3;
    c1 = m1; c2 = m2; c3 = m3;
    if (v.rr) begin
      c1 = 1; c2 = 1; c3 = 1;
    end else if (v.ld && v.l1 inside {[1:26]}
                 && v.l2 inside {[1:26]} && v.l3 inside {[1:26]}) begin
      c1 = v.l1; c2 = v.l2; c3 = v.l3;
    end
    m1 = c1; m2 = c2; m3 = c3;
    if (v.en) begin
      m1 = inc(c1);
      if (c2 == 5) begin
        m2 = inc(c2);
        m3 = inc(c3);
      end else if (c1 == 22) begin
        m2 = inc(c2);
      end
    end
  endtask

  task automatic check_delays(input string tag);
    for (int k = 1; k <= 5; k++)
      chk($sformatf("%s r1_d[%0d]", tag, k), r1_d_o[k], h1[h1.size()-1-k]);
    for (int k = 1; k <= 4; k++)
      chk($sformatf("%s r2_d[%0d]", tag, k), r2_d_o[k], h2[h2.size()-1-k]);
    for (int k = 1; k <= 3; k++)
      chk($sformatf("%s r3_d[%0d]", tag, k), r3_d_o[k], h3[h3.size()-1-k]);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(0, 0,  0, 0,  0, 1,  1,  1, 1,  2);
    tbl[1]  = mk(0, 1,  1, 4, 21, 0,  0,  1, 4, 21);
    tbl[2]  = mk(0, 0,  0, 0,  0, 1,  5,  1, 4, 22);
    tbl[3]  = mk(0, 0,  0, 0,  0, 1,  6,  1, 5, 23);
    tbl[4]  = mk(0, 0,  0, 0,  0, 1,  7,  2, 6, 24);
    tbl[5]  = mk(0, 1,  3, 0,  9, 0,  0,  2, 6, 24);
    tbl[6]  = mk(0, 1,  5, 5,  5, 0,  0,  5, 5,  5);
    tbl[7]  = mk(0, 1,  3, 7,  9, 0,  0,  3, 7,  9);
    tbl[8]  = mk(1, 0,  0, 0,  0, 1,  8,  1, 1,  2);
    tbl[9]  = mk(1, 1,  4, 4,  4, 0,  0,  1, 1,  1);
    tbl[10] = mk(0, 1,  3, 7,  9, 1,  9,  3, 7, 10);
    tbl[11] = mk(0, 0,  0, 0,  0, 0,  3,  3, 7, 10);
    tbl[12] = mk(0, 1,  3, 7, 27, 1, 10,  3, 7, 11);
    tbl[13] = mk(0, 1,  1, 2, 26, 1, 11,  1, 2,  1);
    tbl[14] = mk(0, 1, 26, 5, 22, 1, 12,  1, 6, 23);

    #12;
    check_reset("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 15; i++) drive($sformatf("vec%0d", i), tbl[i]);

    drive("wrap_ld", mk(0, 1, 26, 26, 26, 0, 0, 26, 26, 26));
    chk("wrap_ld b r1", b_r1_o, 26);
    drive("wrap_key", mk(0, 0, 0, 0, 0, 1, 13, 26, 26, 1));
    chk("wrap b r1", b_r1_o, 1);
    chk("wrap b r2", b_r2_o, 1);
    chk("wrap b r3", b_r3_o, 1);
    chk("wrap b en_val_o", b_en_val_o, 1);

    en_val_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check_reset("reset2");
    sbq.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    m1 = 1; m2 = 1; m3 = 1;
    for (int i = 0; i < 6; i++) begin
      h1.push_back(1); h2.push_back(1); h3.push_back(1);
    end

    for (int i = 0; i < 9; i++) begin
      if (i == 0) v = mk(0, 1, 1, 4, 20, 0, 0, 0, 0, 0);
      else        v = mk(0, 0, 0, 0, 0, 1, i + 13, 0, 0, 0);
      mdl(v);
      v.e1 = 7'(m1); v.e2 = 7'(m2); v.e3 = 7'(m3);
      h1.push_back(m1); h2.push_back(m2); h3.push_back(m3);
      drive($sformatf("dly%0d", i), v);
      check_delays($sformatf("dly%0d", i));
    end
    chk("dly final r3", r3_o, 2);

    rst_i = 1'b1;
    #1;
    check_reset("midstream_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    en_val_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
